// File: rtl/vga_timing_axis.sv
// One-axis VGA timing generator: walks FRONT -> SYNC -> BACK -> ACTIVE once per period on en_i ticks.
// Segment lengths are shadow-loaded and take effect at the period boundary.
module vga_timing_axis #(
    parameter int unsigned CNT_W           = 10,
    parameter int unsigned ACTIVE_LEN      = 480,
    parameter int unsigned FRONT_LEN       = 10,
    parameter int unsigned SYNC_LEN        = 2,
    parameter int unsigned BACK_LEN        = 33,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_load_i,
    input  logic [CNT_W-1:0] cfg_active_i,
    input  logic [CNT_W-1:0] cfg_front_i,
    input  logic [CNT_W-1:0] cfg_sync_i,
    input  logic [CNT_W-1:0] cfg_back_i,
    output logic             cfg_pending_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] count_o,
    output logic             active_video_o,
    output logic             sync_pulse_o,
    output logic             active_start_o,
    output logic             period_end_o
);

    typedef enum logic [1:0] {
        ST_FRONT  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_BACK   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEF_ACTIVE = CNT_W'(ACTIVE_LEN);
    localparam logic [CNT_W-1:0] DEF_FRONT  = CNT_W'(FRONT_LEN);
    localparam logic [CNT_W-1:0] DEF_SYNC   = CNT_W'(SYNC_LEN);
    localparam logic [CNT_W-1:0] DEF_BACK   = CNT_W'(BACK_LEN);
    localparam logic             SYNC_ON    = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             active_q, sync_q;

    logic [CNT_W-1:0] live_active, live_front, live_sync, live_back;
    logic [CNT_W-1:0] shad_active, shad_front, shad_sync, shad_back;
    logic             pending;

    logic [CNT_W-1:0] cur_len;
    logic [CNT_W-1:0] last_cnt;
    logic             last_tick;

    // Length of the segment in progress; zero is treated as a one-tick segment.
    always_comb begin
        cur_len = live_front;
        case (state)
            ST_FRONT:  cur_len = live_front;
            ST_SYNC:   cur_len = live_sync;
            ST_BACK:   cur_len = live_back;
            ST_ACTIVE: cur_len = live_active;
            default:   cur_len = live_front;
        endcase
        last_cnt  = (cur_len == '0) ? '0 : cur_len - CNT_W'(1);
        last_tick = (count == last_cnt);
    end

    // Next-state and counter.
    always_comb begin
        state_n = state;
        count_n = count;
        if (en_i) begin
            if (last_tick) begin
                count_n = '0;
                case (state)
                    ST_FRONT:  state_n = ST_SYNC;
                    ST_SYNC:   state_n = ST_BACK;
                    ST_BACK:   state_n = ST_ACTIVE;
                    ST_ACTIVE: state_n = ST_FRONT;
                    default:   state_n = ST_FRONT;
                endcase
            end else begin
                count_n = count + CNT_W'(1);
            end
        end
    end

    // State register; Moore outputs are decoded from the next state so they align with state_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_FRONT;
            count    <= '0;
            active_q <= 1'b0;
            sync_q   <= ~SYNC_ON;
        end else begin
            state    <= state_n;
            count    <= count_n;
            active_q <= (state_n == ST_ACTIVE);
            sync_q   <= (state_n == ST_SYNC) ? SYNC_ON : ~SYNC_ON;
        end
    end

    // Shadow capture and boundary transfer; a load in the same cycle re-arms pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            live_active <= DEF_ACTIVE;
            live_front  <= DEF_FRONT;
            live_sync   <= DEF_SYNC;
            live_back   <= DEF_BACK;
            shad_active <= DEF_ACTIVE;
            shad_front  <= DEF_FRONT;
            shad_sync   <= DEF_SYNC;
            shad_back   <= DEF_BACK;
            pending     <= 1'b0;
        end else begin
            if (period_end_o && pending) begin
                live_active <= shad_active;
                live_front  <= shad_front;
                live_sync   <= shad_sync;
                live_back   <= shad_back;
                pending     <= 1'b0;
            end
            if (cfg_load_i) begin
                shad_active <= cfg_active_i;
                shad_front  <= cfg_front_i;
                shad_sync   <= cfg_sync_i;
                shad_back   <= cfg_back_i;
                pending     <= 1'b1;
            end
        end
    end

    assign active_start_o = en_i && last_tick && (state == ST_BACK);
    assign period_end_o   = en_i && last_tick && (state == ST_ACTIVE);
    assign state_o        = state;
    assign count_o        = count;
    assign active_video_o = active_q;
    assign sync_pulse_o   = sync_q;
    assign cfg_pending_o  = pending;

endmodule
